// File: rtl/i2s_tx_pkg.sv
// Shared constants and types for the I2S transmitter slice.
// The frame is two 32-bit slots; the oscillator count is shared with the synth core.
package i2s_tx_pkg;

  localparam int I2S_SLOT_BITS  = 32;
  localparam int I2S_FRAME_BITS = 64;
  localparam int NUM_OSC        = 8;
  localparam int CNT_W          = $clog2(I2S_FRAME_BITS);

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  // The upper half of the frame counter selects the right slot.
  function automatic slot_e slot_of(input logic [CNT_W-1:0] cnt);
    return slot_e'(cnt[CNT_W-1]);
  endfunction

endpackage

// File: rtl/i2s_tx_bclk_gen.sv
// Bit-clock generator: bclk toggles every BCLK_DIV clk cycles.
// fall marks the clk cycle whose edge drives bclk from 1 to 0.
module bclk_gen
  import i2s_tx_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic fall
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DW-1:0] TC = DW'(BCLK_DIV - 1);

  logic [DW-1:0] div;
  logic          tc;

  assign tc   = (div == TC);
  assign fall = tc & bclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      div  <= '0;
      bclk <= 1'b0;
    end else if (tc) begin
      div  <= '0;
      bclk <= ~bclk;
    end else begin
      div  <= div + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Mono I2S transmitter: one holding register feeds a frame register that is
// serialized MSB-first into both slots with the standard one-bit delay.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int BCLK_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    underrun
);

  logic             fall;
  logic             boundary;
  logic             transfer;
  logic             bit_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [4:0]       pos;
  logic [WIDTH-1:0] frame_reg;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full;
  slot_e            slot;

  bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
    .clk  (clk),
    .rst  (rst),
    .bclk (bclk),
    .fall (fall)
  );

  assign cnt_next = bit_cnt + 1'b1;
  assign pos      = cnt_next[4:0];
  assign boundary = fall && (bit_cnt == CNT_W'(I2S_FRAME_BITS - 1));
  assign transfer = sample_valid && sample_ready;
  assign lrclk    = slot;

  // Slot position p maps to frame_reg[WIDTH-p]; p = 0 and p > WIDTH stay zero.
  always_comb begin
    bit_next = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (int'(pos) == WIDTH - i) bit_next = frame_reg[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '1;
      slot    <= SLOT_LEFT;
      sdata   <= 1'b0;
    end else if (fall) begin
      bit_cnt <= cnt_next;
      slot    <= slot_of(cnt_next);
      sdata   <= bit_next;
    end
  end

  // A boundary load and an upstream transfer never coincide: ready is low while full.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_reg    <= '0;
      hold_reg     <= '0;
      hold_full    <= 1'b0;
      sample_ready <= 1'b1;
      underrun     <= 1'b0;
    end else begin
      underrun <= boundary && !hold_full;
      if (boundary && hold_full) begin
        frame_reg    <= hold_reg;
        hold_full    <= 1'b0;
        sample_ready <= 1'b1;
      end else if (transfer) begin
        hold_reg     <= sample_in;
        hold_full    <= 1'b1;
        sample_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx at BCLK_DIV=2 and BCLK_DIV=1, sharing one stimulus
// stream and comparing every output each cycle against a time-based frame model.
module tb_i2s_tx;

  localparam int W = 24;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                sample_valid = 1'b0;
  logic signed [W-1:0] sample_in = '0;
  logic [1:0]          ready, bclk, lrclk, sdata, underrun;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 1'b0;

  // Model state per instance: edges since reset, holding slot, current frame word.
  int         mN[2];
  logic       mHoldFull[2];
  logic [W-1:0] mHold[2];
  logic [W-1:0] mFrame[2];
  logic       mUnderrun[2];
  logic       mReady[2];

  always #5 clk = ~clk;

  i2s_tx #(.WIDTH(W), .BCLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(ready[0]), .bclk(bclk[0]), .lrclk(lrclk[0]), .sdata(sdata[0]),
    .underrun(underrun[0])
  );

  i2s_tx #(.WIDTH(W), .BCLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(ready[1]), .bclk(bclk[1]), .lrclk(lrclk[1]), .sdata(sdata[1]),
    .underrun(underrun[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: actual=%h expected=%h", tag, $time, actual, expected);
    end
  endtask

  function automatic int divOf(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Completed fall events since reset; fall f (1-based) leaves bit counter at (f-1) mod 64.
  function automatic int fallsOf(input int k);
    return mN[k] / (2 * divOf(k));
  endfunction

  function automatic logic expSdata(input int k);
    int f, p;
    f = fallsOf(k);
    if (f == 0) return 1'b0;
    p = ((f - 1) % 64) % 32;
    if (p >= 1 && p <= W) return mFrame[k][W - p];
    return 1'b0;
  endfunction

  function automatic logic expLrclk(input int k);
    int f;
    f = fallsOf(k);
    return (f > 0) && (((f - 1) % 64) >= 32);
  endfunction

  task automatic modelStep(input int k);
    int  d;
    logic fallEv, boundary, xfer;
    d = divOf(k);
    if (rst) begin
      mN[k] = 0; mHoldFull[k] = 1'b0; mHold[k] = '0; mFrame[k] = '0;
      mUnderrun[k] = 1'b0; mReady[k] = 1'b1;
    end else begin
      xfer     = sample_valid && mReady[k];
      mN[k]    = mN[k] + 1;
      fallEv   = (mN[k] % (2 * d)) == 0;
      boundary = fallEv && (((mN[k] / (2 * d)) - 1) % 64 == 0);
      mUnderrun[k] = 1'b0;
      if (boundary) begin
        if (mHoldFull[k]) begin
          mFrame[k]    = mHold[k];
          mHoldFull[k] = 1'b0;
        end else begin
          mUnderrun[k] = 1'b1;
        end
      end
      if (xfer) begin
        mHold[k]     = sample_in;
        mHoldFull[k] = 1'b1;
      end
      mReady[k] = !mHoldFull[k];
    end
  endtask

  always @(posedge clk) begin
    modelStep(0);
    modelStep(1);
  end

  always @(negedge clk) begin
    if (checkEn) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("bclk%0d", k), 32'(bclk[k]), 32'((mN[k] / divOf(k)) % 2));
        checkOutput($sformatf("lrclk%0d", k), 32'(lrclk[k]), 32'(expLrclk(k)));
        checkOutput($sformatf("sdata%0d", k), 32'(sdata[k]), 32'(expSdata(k)));
        checkOutput($sformatf("ready%0d", k), 32'(ready[k]), 32'(mReady[k]));
        checkOutput($sformatf("underrun%0d", k), 32'(underrun[k]), 32'(mUnderrun[k]));
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [W-1:0] s, input int cycles);
    sample_valid = v;
    sample_in    = s;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkEn = 1'b1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_bclk"}, 32'(bclk[0]), 32'd0);
    checkOutput({tag, "_lrclk"}, 32'(lrclk[0]), 32'd0);
    checkOutput({tag, "_sdata"}, 32'(sdata[0]), 32'd0);
    checkOutput({tag, "_underrun"}, 32'(underrun[0]), 32'd0);
    checkOutput({tag, "_ready"}, 32'(ready[0]), 32'd1);
  endtask

  task automatic offerSample(input logic [W-1:0] s, output int waited);
    logic r;
    r = 1'b0;
    waited = 0;
    sample_valid = 1'b1;
    sample_in    = s;
    for (int i = 0; i < 1000; i++) begin
      r = ready[0];
      @(negedge clk);
      if (r) break;
      waited++;
    end
    if (!r) checkOutput("offer_timeout", 32'(r), 32'd1);
    sample_valid = 1'b0;
  endtask

  initial begin
    int waited, rise, ones;
    logic prevB, prevL;
    logic [31:0] leftBits, rightBits;
    int urTimes[$];
    int lrTimes[$];

    // Single sample before the first boundary lands in both slots of frame 0.
    applyReset();
    checkResetValues("reset");
    applyStimulus(1'b1, 24'h800001, 1);
    sample_valid = 1'b0;
    prevB = bclk[0];
    rise = 0; leftBits = '0; rightBits = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bclk[0] && !prevB) begin
        rise++;
        if (rise >= 2 && rise <= 33) leftBits = {leftBits[30:0], sdata[0]};
        else if (rise >= 34 && rise <= 65) rightBits = {rightBits[30:0], sdata[0]};
      end
      prevB = bclk[0];
    end
    checkOutput("req030_left", leftBits, 32'h4000_0080);
    checkOutput("req030_right", rightBits, 32'h4000_0080);

    // Idle source: underrun every frame, lrclk period at BCLK_DIV=1.
    applyReset();
    prevL = lrclk[1];
    for (int i = 1; i <= 800; i++) begin
      @(negedge clk);
      if (underrun[0]) urTimes.push_back(i);
      if (lrclk[1] && !prevL) lrTimes.push_back(i);
      prevL = lrclk[1];
    end
    checkOutput("req031_count", 32'(urTimes.size()), 32'd4);
    if (urTimes.size() >= 3) begin
      checkOutput("req031_gap1", 32'(urTimes[1] - urTimes[0]), 32'd256);
      checkOutput("req031_gap2", 32'(urTimes[2] - urTimes[1]), 32'd256);
    end
    checkOutput("req035_lr_count", 32'(lrTimes.size() >= 2), 32'd1);
    if (lrTimes.size() >= 2)
      checkOutput("req035_lr_period", 32'(lrTimes[1] - lrTimes[0]), 32'd128);

    // Sample offered exactly on the boundary cycle with hold empty.
    applyReset();
    applyStimulus(1'b0, '0, 3);
    applyStimulus(1'b1, 24'h5A5A5A, 1);
    sample_valid = 1'b0;
    checkOutput("req033_underrun", 32'(underrun[0]), 32'd1);
    checkOutput("req033_ready", 32'(ready[0]), 32'd0);
    applyStimulus(1'b0, '0, 300);

    // Back-to-back A then B: B waits for A to load at the first boundary.
    applyReset();
    offerSample(24'h123456, waited);
    checkOutput("req032_a_wait", 32'(waited), 32'd0);
    offerSample(24'hABCDEF, waited);
    checkOutput("req032_b_wait", 32'(waited), 32'd3);
    applyStimulus(1'b0, '0, 600);

    // Reset at bit 40 of a frame while a sample is held.
    applyReset();
    offerSample(24'h0F0F0F, waited);
    offerSample(24'hFFFFFF, waited);
    waited = 0;
    while (!(fallsOf(0) > 0 && ((fallsOf(0) - 1) % 64) == 40) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("req034_reach40", 32'(waited < 2000), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkResetValues("req034");
    rst = 1'b0;
    ones = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (sdata[0]) ones++;
    end
    checkOutput("req034_no_held", 32'(ones), 32'd0);

    // Random traffic: sparse first (underruns), then dense (hold always full).
    applyReset();
    for (int i = 0; i < 3000; i++) begin
      sample_valid = ($urandom_range(0, 999) < ((i < 1500) ? 3 : 400));
      sample_in    = W'($urandom);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter WIDTH, default 24, sample width in bits; legal range 8..31.
REQ-002 Parameter BCLK_DIV, default 4, clk cycles per bclk half-period; minimum 1.
REQ-003 clk  input  1  system clock; all state on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sample_in  input  WIDTH signed  mixed mono sample from mixer output.
REQ-006 sample_valid  input  1  sample_in valid this cycle; may be tied to the sample-rate strobe.
REQ-007 sample_ready  output  1  holding register empty; transfer when sample_valid && sample_ready.
REQ-008 bclk  output  1  I2S bit clock, idle low.
REQ-009 lrclk  output  1  word select; 0 = left slot, 1 = right slot.
REQ-010 sdata  output  1  serial data, MSB first, changes only on bclk falling edges.
REQ-011 underrun  output  1  one-cycle pulse when a frame starts with no new sample.

Function
REQ-012 Divider counts 0..BCLK_DIV-1; at terminal count bclk toggles, so bclk period = 2*BCLK_DIV clk cycles.
REQ-013 A "fall event" is the clk cycle in which bclk toggles 1->0; bit_cnt (6 bits, 0..63) increments modulo 64 on each fall event.
REQ-014 lrclk, sdata and bit_cnt update in the same cycle as the fall event (registered, no extra latency).
REQ-015 lrclk = 0 for bit_cnt 0..31, 1 for bit_cnt 32..63.
REQ-016 Slot position p = bit_cnt mod 32; p = 0 drives 0; p = 1..WIDTH drives frame_reg[WIDTH-p]; p > WIDTH drives 0 (standard I2S one-bit delay, zero padding).
REQ-017 Both slots carry the same frame_reg value (mono duplicated to left and right).
REQ-018 Frame boundary = fall event where bit_cnt wraps 63->0; at that event frame_reg loads from the holding register if it is full, and the holding register is marked empty.
REQ-019 At a frame boundary with the holding register empty, frame_reg keeps its previous value and underrun pulses high for exactly that cycle.
REQ-020 sample_ready = NOT hold_full, registered; a transfer sets hold_full next cycle; a frame-boundary load clears it next cycle.
REQ-021 Simultaneous valid and frame-boundary load with hold_full = 1: no transfer (ready is 0); the old holding value loads; ready rises next cycle.
REQ-022 Simultaneous transfer and frame boundary with hold_full = 0: underrun pulses; the new sample is held for the next frame.
REQ-023 sample_in is captured only on transfer; sample_in is ignored while sample_ready = 0.
REQ-024 Frame rate = clk / (128*BCLK_DIV); the upstream source owns sample-rate matching.

Reset
REQ-025 On rst: bclk = 0, lrclk = 0, sdata = 0, underrun = 0, sample_ready = 1, divider = 0, bit_cnt = 63, frame_reg = 0, hold_full = 0.
REQ-026 The first fall event after reset wraps bit_cnt to 0 and is a frame boundary.
REQ-027 Reset asserted mid-frame aborts the frame immediately; a held sample is discarded.

Structure
REQ-028 I2S_SLOT_BITS (32) and I2S_FRAME_BITS (64) live in the shared constants header alongside the oscillator count.
REQ-029 The bclk generator is one sub-module, bclk_gen (clk, rst, bclk, fall-event strobe); everything else is in i2s_tx.

Verification
REQ-030 BCLK_DIV=2, sample 24'h800001 accepted before the first boundary -> sdata in left slot p=1..24 = 1, 22 zeros, 1; p=0 and p=25..31 = 0; right slot identical.
REQ-031 No sample_valid after reset -> underrun pulses at every frame boundary (every 256 clk cycles at BCLK_DIV=2); sdata all 0.
REQ-032 Two samples A=24'h123456 then B=24'hABCDEF offered back-to-back -> A accepted; ready stays 0 until A loads; B is accepted after that; frames carry A then B.
REQ-033 Valid asserted exactly on the frame-boundary cycle with hold empty -> underrun pulses; the sample appears in the following frame.
REQ-034 rst asserted at bit_cnt=40 -> next cycle all outputs equal their REQ-025 values; the pending held sample never appears on sdata.
REQ-035 BCLK_DIV=1 -> bclk toggles every clk cycle; lrclk period = 128 clk cycles; sdata stable across every bclk rising edge.
